// File: rtl/mvp_cand_sel_pkg.sv
// Shared widths, FSM encodings and the per-component MVD bit estimator.
// The width macros normally come from enc_defines.v. Fallbacks apply only when that file has
// not been compiled ahead of this package.
`ifndef FMV_WIDTH
`define FMV_WIDTH 10
`endif
`ifndef MVD_WIDTH
`define MVD_WIDTH 11
`endif
`ifndef MVP_NUM
`define MVP_NUM 2
`endif
`ifndef ST_IDLE
`define ST_IDLE 2'd0
`define ST_EVAL 2'd1
`define ST_DONE 2'd2
`endif

package mvp_cand_sel_pkg;

    localparam int unsigned FmvWidth  = `FMV_WIDTH;
    localparam int unsigned MvdWidth  = `MVD_WIDTH;
    localparam int unsigned BitsWidth = 7;

    typedef enum logic [1:0] {
        StIdle = `ST_IDLE,
        StEval = `ST_EVAL,
        StDone = `ST_DONE
    } state_e;

    // Exp-Golomb style length of one MVD component, saturated at 63. The field is read as a
    // magnitude. A set sign bit (a negative difference) costs the full 63.
    function automatic logic [BitsWidth-1:0] comp_bits(input logic [MvdWidth-1:0] v);
        logic [BitsWidth-1:0] len;
        len = 7'd1;
        if (v[MvdWidth-1]) begin
            len = 7'd63;
        end else begin
            for (int i = 0; i < int'(MvdWidth) - 1; i++) begin
                if (v[i]) len = 7'(2 * i + 3);
            end
        end
        if (len > 7'd63) len = 7'd63;
        return len;
    endfunction

endpackage

// File: rtl/mvp_cand_sel_mvd_getbits.sv
// Combinational MVD and bit estimate for one predictor candidate.
// The output packs mvd as {mvd_x, mvd_y}. The input MVs pack as {y, x}.
module mvd_getBits
    import mvp_cand_sel_pkg::*;
(
    input  logic [2*FmvWidth-1:0]  mv,
    input  logic [2*FmvWidth-1:0]  mvp,
    output logic [2*MvdWidth-1:0]  mvd,
    output logic [BitsWidth-1:0]   bits
);

    logic [MvdWidth-1:0] mvd_x;
    logic [MvdWidth-1:0] mvd_y;

    // Sign-extend both MVs, subtract at MVD width (wraps, no saturation), then estimate bits.
    always_comb begin
        mvd_x = MvdWidth'($signed(mv[FmvWidth-1:0])) - MvdWidth'($signed(mvp[FmvWidth-1:0]));
        mvd_y = MvdWidth'($signed(mv[2*FmvWidth-1:FmvWidth]))
              - MvdWidth'($signed(mvp[2*FmvWidth-1:FmvWidth]));
        mvd   = {mvd_x, mvd_y};
        bits  = comp_bits(mvd_x) + comp_bits(mvd_y);
    end

endmodule

// File: rtl/mvp_cand_sel.sv
// AMVP candidate selection: evaluates one candidate per cycle and keeps the cheapest.
module mvp_cand_sel
    import mvp_cand_sel_pkg::*;
#(
    parameter int unsigned MVP_NUM      = `MVP_NUM,
    parameter int unsigned LAMBDA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic [2*FmvWidth-1:0]           mv_i,
    input  logic [MVP_NUM*2*FmvWidth-1:0]   mvp_cand_i,
    input  logic [CNT_WIDTH-1:0]            mvp_num_i,
    input  logic [LAMBDA_WIDTH-1:0]         lambda_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [CNT_WIDTH-1:0]            mvp_idx_o,
    output logic [2*MvdWidth-1:0]           mvd_o,
    output logic [BitsWidth-1:0]            mv_bits_o,
    output logic [BitsWidth+LAMBDA_WIDTH-1:0] mv_cost_o
);

    localparam int unsigned CandW = 2 * FmvWidth;
    localparam int unsigned CostW = BitsWidth + LAMBDA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] MaxCnt = CNT_WIDTH'(MVP_NUM);

    state_e                   state_q, state_d;
    logic [CandW-1:0]         mv_q;
    logic [CandW-1:0]         cand_q [MVP_NUM];
    logic [LAMBDA_WIDTH-1:0]  lambda_q;
    logic [CNT_WIDTH-1:0]     idx_q, last_q;
    logic [BitsWidth-1:0]     best_bits_q;
    logic [CNT_WIDTH-1:0]     best_idx_q;
    logic [2*MvdWidth-1:0]    best_mvd_q;
    logic [CNT_WIDTH-1:0]     res_idx_q;
    logic [2*MvdWidth-1:0]    res_mvd_q;
    logic [BitsWidth-1:0]     res_bits_q;
    logic [CostW-1:0]         res_cost_q;

    logic [CNT_WIDTH-1:0]     num_eff;
    logic [CandW-1:0]         cur_cand;
    logic [2*MvdWidth-1:0]    cur_mvd;
    logic [BitsWidth-1:0]     cur_bits;
    logic                     take;
    logic [BitsWidth-1:0]     fin_bits;
    logic [CNT_WIDTH-1:0]     fin_idx;
    logic [2*MvdWidth-1:0]    fin_mvd;

    // Clamp the requested candidate count to 1..MVP_NUM.
    always_comb begin
        num_eff = mvp_num_i;
        if (mvp_num_i == '0) begin
            num_eff = CNT_WIDTH'(1);
        end else if (mvp_num_i > MaxCnt) begin
            num_eff = MaxCnt;
        end
    end

    // Select the candidate under evaluation.
    always_comb begin
        cur_cand = '0;
        for (int k = 0; k < int'(MVP_NUM); k++) begin
            if (idx_q == CNT_WIDTH'(k)) cur_cand = cand_q[k];
        end
    end

    mvd_getBits u_getbits (
        .mv   (mv_q),
        .mvp  (cur_cand),
        .mvd  (cur_mvd),
        .bits (cur_bits)
    );

    // Running best with the current candidate folded in. Strict less keeps the lower index on ties.
    always_comb begin
        take     = cur_bits < best_bits_q;
        fin_bits = take ? cur_bits : best_bits_q;
        fin_idx  = take ? idx_q    : best_idx_q;
        fin_mvd  = take ? cur_mvd  : best_mvd_q;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StEval;
            StEval:  if (idx_q == last_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Request latch, search bookkeeping and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mv_q        <= '0;
            for (int k = 0; k < int'(MVP_NUM); k++) cand_q[k] <= '0;
            lambda_q    <= '0;
            idx_q       <= '0;
            last_q      <= '0;
            best_bits_q <= '0;
            best_idx_q  <= '0;
            best_mvd_q  <= '0;
            res_idx_q   <= '0;
            res_mvd_q   <= '0;
            res_bits_q  <= '0;
            res_cost_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mv_q <= mv_i;
                        for (int k = 0; k < int'(MVP_NUM); k++) begin
                            cand_q[k] <= mvp_cand_i[k*CandW +: CandW];
                        end
                        lambda_q    <= lambda_i;
                        idx_q       <= '0;
                        last_q      <= num_eff - CNT_WIDTH'(1);
                        best_bits_q <= 7'h7F;
                        best_idx_q  <= '0;
                        best_mvd_q  <= '0;
                    end
                end
                StEval: begin
                    best_bits_q <= fin_bits;
                    best_idx_q  <= fin_idx;
                    best_mvd_q  <= fin_mvd;
                    idx_q       <= idx_q + CNT_WIDTH'(1);
                    // Results land on entry to DONE so they are valid while done_o is high.
                    if (idx_q == last_q) begin
                        res_idx_q  <= fin_idx;
                        res_mvd_q  <= fin_mvd;
                        res_bits_q <= fin_bits;
                        res_cost_q <= CostW'(fin_bits) * CostW'(lambda_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign done_o    = (state_q == StDone);
    assign mvp_idx_o = res_idx_q;
    assign mvd_o     = res_mvd_q;
    assign mv_bits_o = res_bits_q;
    assign mv_cost_o = res_cost_q;

endmodule
